// File: rtl/branch_predictor_ctrl_pkg.sv
// Shared definitions for the global-history branch predictor (bp_defines):
// default geometry, sequencer state encoding and 2-bit counter encoding.
package branch_predictor_ctrl_pkg;

   localparam logic [1:0] CTR_SNT = 2'd0;
   localparam logic [1:0] CTR_WNT = 2'd1;
   localparam logic [1:0] CTR_WT  = 2'd2;
   localparam logic [1:0] CTR_ST  = 2'd3;

   localparam int unsigned BP_HIST_BITS = 8;
   localparam logic [1:0]  BP_CTR_INIT  = CTR_WT;

   typedef enum logic [1:0] {
      ST_INIT   = 2'd0,
      ST_IDLE   = 2'd1,
      ST_UPD_RD = 2'd2,
      ST_UPD_WR = 2'd3
   } bp_state_e;

   // Saturating step of a 2-bit counter; never wraps between 0 and 3.
   function automatic logic [1:0] ctr_update(input logic [1:0] ctr, input logic taken);
      logic [1:0] nxt;
      case (ctr)
         CTR_SNT: nxt = taken ? CTR_WNT : CTR_SNT;
         CTR_WNT: nxt = taken ? CTR_WT  : CTR_SNT;
         CTR_WT:  nxt = taken ? CTR_ST  : CTR_WNT;
         CTR_ST:  nxt = taken ? CTR_ST  : CTR_WT;
         default: nxt = CTR_WT;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/bp_update_fifo.sv
// Two-entry FIFO of resolved branches {index, taken}; shared by predictor variants.
module bp_update_fifo #(
   parameter int unsigned WIDTH = 9
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem_q [2];
   logic [WIDTH-1:0] mem_d [2];
   logic             wr_ptr_q, wr_ptr_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic [1:0]       count_q, count_d;
   logic             push_ok_s;
   logic             pop_ok_s;

   assign full      = (count_q == 2'd2);
   assign empty     = (count_q == 2'd0);
   assign push_ok_s = push & ~full;
   assign pop_ok_s  = pop & ~empty;
   assign head_data = mem_q[rd_ptr_q];

   // Next-state for storage, pointers and occupancy.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok_s) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = ~wr_ptr_q;
      end else begin
         wr_ptr_d = wr_ptr_q;
      end
      if (pop_ok_s) begin
         rd_ptr_d = ~rd_ptr_q;
      end else begin
         rd_ptr_d = rd_ptr_q;
      end
      case ({push_ok_s, pop_ok_s})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   // FIFO state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/branch_predictor_ctrl.sv
// PHT sequencer: post-reset init sweep, lookup/update port arbitration with
// read-modify-write counter updates, and global history register ownership.
module branch_predictor_ctrl
   import branch_predictor_ctrl_pkg::*;
#(
   parameter int unsigned HIST_BITS = BP_HIST_BITS,
   parameter logic [1:0]  CTR_INIT  = BP_CTR_INIT
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 lookup_valid,
   output logic                 lookup_ready,
   output logic                 pred_valid,
   output logic                 pred_taken,
   output logic [HIST_BITS-1:0] pred_index,
   input  logic                 resolve_valid,
   input  logic                 resolve_taken,
   input  logic [HIST_BITS-1:0] resolve_index,
   output logic                 resolve_ready,
   output logic                 tbl_en,
   output logic                 tbl_we,
   output logic [HIST_BITS-1:0] tbl_addr,
   output logic [1:0]           tbl_wdata,
   input  logic [1:0]           tbl_rdata,
   output logic [HIST_BITS-1:0] ghr,
   output logic                 init_done
);

   localparam logic [HIST_BITS-1:0] LAST_ADDR = {HIST_BITS{1'b1}};
   localparam logic [HIST_BITS-1:0] ADDR_ONE  = {{(HIST_BITS-1){1'b0}}, 1'b1};

   bp_state_e            state_q, state_d;
   logic [HIST_BITS-1:0] sweep_q, sweep_d;
   logic                 init_wr_q, init_wr_d;
   logic                 init_done_q, init_done_d;
   logic [HIST_BITS-1:0] ghr_q, ghr_d;
   logic                 pred_valid_q, pred_valid_d;
   logic [HIST_BITS-1:0] pred_index_q, pred_index_d;
   logic                 rd_issued_q, rd_issued_d;
   logic [1:0]           hold_q, hold_d;

   logic                 lookup_fire_s;
   logic                 fifo_push_s;
   logic                 fifo_pop_s;
   logic                 fifo_full_s;
   logic                 fifo_empty_s;
   logic [HIST_BITS:0]   fifo_head_s;
   logic [HIST_BITS-1:0] head_index_s;
   logic                 head_taken_s;
   logic [1:0]           ctr_src_s;
   logic                 upd_en_s;
   logic                 upd_we_s;
   logic [1:0]           upd_wdata_s;

   bp_update_fifo #(
      .WIDTH (HIST_BITS + 1)
   ) u_update_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (fifo_push_s),
      .push_data ({resolve_index, resolve_taken}),
      .pop       (fifo_pop_s),
      .head_data (fifo_head_s),
      .full      (fifo_full_s),
      .empty     (fifo_empty_s)
   );

   assign lookup_ready  = init_done_q & ~fifo_full_s;
   assign resolve_ready = init_done_q & ~fifo_full_s;
   assign lookup_fire_s = lookup_valid & lookup_ready;
   assign fifo_push_s   = resolve_valid & resolve_ready;
   assign head_index_s  = fifo_head_s[HIST_BITS:1];
   assign head_taken_s  = fifo_head_s[0];

   // Read data is live only the cycle after the update read; later it comes from the holding register.
   assign ctr_src_s     = rd_issued_q ? tbl_rdata : hold_q;

   assign init_done     = init_done_q;
   assign ghr           = ghr_q;
   assign pred_valid    = pred_valid_q;
   assign pred_index    = pred_index_q;
   assign pred_taken    = pred_valid_q & tbl_rdata[1];

   // Sequencer: init sweep, then update read/write that yields to accepted lookups.
   always_comb begin
      state_d     = state_q;
      sweep_d     = sweep_q;
      init_wr_d   = init_wr_q;
      init_done_d = init_done_q;
      rd_issued_d = 1'b0;
      fifo_pop_s  = 1'b0;
      upd_en_s    = 1'b0;
      upd_we_s    = 1'b0;
      upd_wdata_s = 2'b00;
      case (state_q)
         ST_INIT: begin
            if (init_wr_q) begin
               sweep_d = sweep_q + ADDR_ONE;
               if (sweep_q == LAST_ADDR) begin
                  state_d     = ST_IDLE;
                  init_wr_d   = 1'b0;
                  init_done_d = 1'b1;
               end else begin
                  init_wr_d = 1'b1;
               end
            end else begin
               init_wr_d = 1'b1;
            end
         end
         ST_IDLE: begin
            if (!fifo_empty_s || fifo_push_s) begin
               state_d = ST_UPD_RD;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_UPD_RD: begin
            if (lookup_fire_s) begin
               state_d = ST_UPD_RD;
            end else begin
               upd_en_s    = 1'b1;
               rd_issued_d = 1'b1;
               state_d     = ST_UPD_WR;
            end
         end
         ST_UPD_WR: begin
            if (lookup_fire_s) begin
               state_d = ST_UPD_WR;
            end else begin
               upd_en_s    = 1'b1;
               upd_we_s    = 1'b1;
               upd_wdata_s = ctr_update(ctr_src_s, head_taken_s);
               fifo_pop_s  = 1'b1;
               // A full FIFO still holds one entry after this pop.
               if (fifo_full_s || fifo_push_s) begin
                  state_d = ST_UPD_RD;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: begin
            state_d   = ST_INIT;
            sweep_d   = '0;
            init_wr_d = 1'b0;
         end
      endcase
   end

   // PHT port mux: lookup has priority over sweep and update traffic.
   always_comb begin
      tbl_en    = 1'b0;
      tbl_we    = 1'b0;
      tbl_addr  = '0;
      tbl_wdata = 2'b00;
      if (lookup_fire_s) begin
         tbl_en   = 1'b1;
         tbl_addr = ghr_q;
      end else if (init_wr_q) begin
         tbl_en    = 1'b1;
         tbl_we    = 1'b1;
         tbl_addr  = sweep_q;
         tbl_wdata = CTR_INIT;
      end else begin
         tbl_en    = upd_en_s;
         tbl_we    = upd_we_s;
         tbl_addr  = head_index_s;
         tbl_wdata = upd_wdata_s;
      end
   end

   // History shift, prediction tracking and update read-data capture.
   always_comb begin
      ghr_d        = ghr_q;
      pred_valid_d = lookup_fire_s;
      pred_index_d = pred_index_q;
      hold_d       = hold_q;
      if (fifo_push_s) begin
         ghr_d = {ghr_q[HIST_BITS-2:0], resolve_taken};
      end else begin
         ghr_d = ghr_q;
      end
      if (lookup_fire_s) begin
         pred_index_d = ghr_q;
      end else begin
         pred_index_d = pred_index_q;
      end
      if (rd_issued_q) begin
         hold_d = tbl_rdata;
      end else begin
         hold_d = hold_q;
      end
   end

   // Controller state registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_INIT;
         sweep_q      <= '0;
         init_wr_q    <= 1'b0;
         init_done_q  <= 1'b0;
         ghr_q        <= '0;
         pred_valid_q <= 1'b0;
         pred_index_q <= '0;
         rd_issued_q  <= 1'b0;
         hold_q       <= 2'b00;
      end else begin
         state_q      <= state_d;
         sweep_q      <= sweep_d;
         init_wr_q    <= init_wr_d;
         init_done_q  <= init_done_d;
         ghr_q        <= ghr_d;
         pred_valid_q <= pred_valid_d;
         pred_index_q <= pred_index_d;
         rd_issued_q  <= rd_issued_d;
         hold_q       <= hold_d;
      end
   end

endmodule

// File: tb/tb_branch_predictor_ctrl.sv
// Scoreboard bench for branch_predictor_ctrl with a behavioural 1-cycle PHT RAM.
module tb_branch_predictor_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       lookup_valid;
   logic       lookup_ready;
   logic       pred_valid;
   logic       pred_taken;
   logic [7:0] pred_index;
   logic       resolve_valid;
   logic       resolve_taken;
   logic [7:0] resolve_index;
   logic       resolve_ready;
   logic       tbl_en;
   logic       tbl_we;
   logic [7:0] tbl_addr;
   logic [1:0] tbl_wdata;
   logic [1:0] tbl_rdata;
   logic [7:0] ghr;
   logic       init_done;

   logic [1:0] pht [0:255];
   logic [1:0] rdata_r;

   int         vec_cnt = 0;
   int         err_cnt = 0;
   int         cyc_cnt = 0;
   int         last_wr_cyc = 0;
   int         last_pred_cyc = 0;
   logic [9:0] exp_wr_q [$];
   logic [8:0] exp_pred_q [$];

   always #5 clk = ~clk;

   branch_predictor_ctrl #(
      .HIST_BITS (8),
      .CTR_INIT  (2'b10)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .lookup_valid  (lookup_valid),
      .lookup_ready  (lookup_ready),
      .pred_valid    (pred_valid),
      .pred_taken    (pred_taken),
      .pred_index    (pred_index),
      .resolve_valid (resolve_valid),
      .resolve_taken (resolve_taken),
      .resolve_index (resolve_index),
      .resolve_ready (resolve_ready),
      .tbl_en        (tbl_en),
      .tbl_we        (tbl_we),
      .tbl_addr      (tbl_addr),
      .tbl_wdata     (tbl_wdata),
      .tbl_rdata     (tbl_rdata),
      .ghr           (ghr),
      .init_done     (init_done)
   );

   assign tbl_rdata = rdata_r;

   always @(posedge clk) begin
      if (tbl_en) begin
         if (tbl_we) pht[tbl_addr] <= tbl_wdata;
         else        rdata_r <= pht[tbl_addr];
      end
   end

   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      vec_cnt++;
      if (act !== req) begin
         err_cnt++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Monitor: every PHT write and every prediction is matched against the scoreboard.
   initial begin
      logic [9:0] ew;
      logic [8:0] ep;
      forever begin
         @(negedge clk);
         if (tbl_en === 1'b1 && tbl_we === 1'b1) begin
            last_wr_cyc = cyc_cnt;
            if (exp_wr_q.size() == 0) begin
               vec_cnt++;
               err_cnt++;
               $display("FAIL unexpected_write: actual addr=%0h data=%0h, required none", tbl_addr, tbl_wdata);
            end else begin
               ew = exp_wr_q.pop_front();
               check("wr_addr", {24'd0, tbl_addr}, {24'd0, ew[9:2]});
               check("wr_data", {30'd0, tbl_wdata}, {30'd0, ew[1:0]});
            end
         end
         if (pred_valid === 1'b1) begin
            last_pred_cyc = cyc_cnt;
            if (exp_pred_q.size() == 0) begin
               vec_cnt++;
               err_cnt++;
               $display("FAIL unexpected_pred: actual index=%0h, required none", pred_index);
            end else begin
               ep = exp_pred_q.pop_front();
               check("pred_taken", {31'd0, pred_taken}, {31'd0, ep[8]});
               check("pred_index", {24'd0, pred_index}, {24'd0, ep[7:0]});
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic queue_sweep();
      for (int i = 0; i < 256; i++) begin
         logic [7:0] a;
         a = i[7:0];
         exp_wr_q.push_back({a, 2'b10});
      end
   endtask

   // Called right after rst_n release (posedge+1); returns the cycle init_done is first seen.
   task automatic wait_init(output int n, output logic bad);
      n   = 0;
      bad = 1'b0;
      while (init_done !== 1'b1 && n < 400) begin
         @(posedge clk);
         @(negedge clk);
         n++;
         if (init_done !== 1'b1 && (lookup_ready !== 1'b0 || resolve_ready !== 1'b0)) bad = 1'b1;
      end
   endtask

   task automatic resolve(input logic [7:0] idx, input logic tkn, input logic [1:0] wexp, output int push_cyc);
      exp_wr_q.push_back({idx, wexp});
      resolve_index = idx;
      resolve_taken = tkn;
      resolve_valid = 1'b1;
      push_cyc      = cyc_cnt;
      tick();
      resolve_valid = 1'b0;
      tick();
      tick();
      tick();
   endtask

   task automatic lookup(input logic [8:0] pexp);
      exp_pred_q.push_back(pexp);
      lookup_valid = 1'b1;
      tick();
      lookup_valid = 1'b0;
      tick();
   endtask

   initial begin
      int   n;
      int   pc;
      logic bad;
      rst_n         = 1'b0;
      lookup_valid  = 1'b0;
      resolve_valid = 1'b0;
      resolve_taken = 1'b0;
      resolve_index = 8'h00;
      queue_sweep();
      tick();
      tick();
      @(negedge clk);
      check("rst_init_done", {31'd0, init_done}, 32'd0);
      check("rst_tbl_en", {31'd0, tbl_en}, 32'd0);
      check("rst_ghr", {24'd0, ghr}, 32'd0);
      check("rst_pred_valid", {31'd0, pred_valid}, 32'd0);
      check("rst_lookup_ready", {31'd0, lookup_ready}, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      wait_init(n, bad);
      check("init_cycles", n, 32'd257);
      check("ready_during_init", {31'd0, bad}, 32'd0);
      check("init_writes_left", exp_wr_q.size(), 32'd0);
      tick();

      lookup({1'b1, 8'h00});
      resolve(8'h00, 1'b1, 2'd3, pc);
      check("upd_latency", last_wr_cyc, pc + 2);
      check("ghr_after_t", {24'd0, ghr}, 32'h01);
      resolve(8'h00, 1'b1, 2'd3, pc);
      resolve(8'h00, 1'b0, 2'd2, pc);
      resolve(8'h00, 1'b0, 2'd1, pc);
      resolve(8'h00, 1'b0, 2'd0, pc);
      resolve(8'h00, 1'b0, 2'd0, pc);
      check("ghr_after_sat", {24'd0, ghr}, 32'h30);
      lookup({1'b1, 8'h30});

      // Contention: update pushed in N, lookup to the same index in N+2.
      exp_wr_q.push_back({8'h60, 2'd1});
      resolve_index = 8'h60;
      resolve_taken = 1'b0;
      resolve_valid = 1'b1;
      pc            = cyc_cnt;
      tick();
      resolve_valid = 1'b0;
      tick();
      exp_pred_q.push_back({1'b1, 8'h60});
      lookup_valid = 1'b1;
      tick();
      lookup_valid = 1'b0;
      tick();
      tick();
      check("contend_wr_cycle", last_wr_cyc, pc + 3);
      check("contend_pred_cycle", last_pred_cyc, pc + 3);
      lookup({1'b0, 8'h60});

      // Back-pressure: resolves and lookups held every cycle.
      exp_pred_q.push_back({1'b0, 8'h60});
      exp_pred_q.push_back({1'b1, 8'hC1});
      exp_wr_q.push_back({8'h40, 2'd3});
      exp_wr_q.push_back({8'h40, 2'd3});
      resolve_index = 8'h40;
      resolve_taken = 1'b1;
      resolve_valid = 1'b1;
      lookup_valid  = 1'b1;
      tick();
      tick();
      @(negedge clk);
      check("bp_full_resolve_ready", {31'd0, resolve_ready}, 32'd0);
      check("bp_full_lookup_ready", {31'd0, lookup_ready}, 32'd0);
      tick();
      @(negedge clk);
      check("bp_pop_resolve_ready", {31'd0, resolve_ready}, 32'd0);
      check("bp_pop_lookup_ready", {31'd0, lookup_ready}, 32'd0);
      tick();
      resolve_valid = 1'b0;
      lookup_valid  = 1'b0;
      @(negedge clk);
      check("bp_drain_resolve_ready", {31'd0, resolve_ready}, 32'd1);
      check("bp_drain_lookup_ready", {31'd0, lookup_ready}, 32'd1);
      tick();
      tick();
      tick();
      tick();
      check("bp_ghr", {24'd0, ghr}, 32'h83);

      // Reset while the update is in its write cycle.
      resolve_index = 8'h22;
      resolve_taken = 1'b1;
      resolve_valid = 1'b1;
      tick();
      resolve_valid = 1'b0;
      tick();
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_tbl_en", {31'd0, tbl_en}, 32'd0);
      check("midrst_ghr", {24'd0, ghr}, 32'd0);
      check("midrst_init_done", {31'd0, init_done}, 32'd0);
      check("midrst_pred_valid", {31'd0, pred_valid}, 32'd0);
      check("midrst_resolve_ready", {31'd0, resolve_ready}, 32'd0);
      queue_sweep();
      tick();
      tick();
      rst_n = 1'b1;
      wait_init(n, bad);
      check("reinit_cycles", n, 32'd257);
      check("reready_during_init", {31'd0, bad}, 32'd0);
      check("reinit_writes_left", exp_wr_q.size(), 32'd0);
      tick();
      check("reinit_resolve_ready", {31'd0, resolve_ready}, 32'd1);

      resolve(8'h0A, 1'b1, 2'd3, pc);
      resolve(8'h0B, 1'b0, 2'd1, pc);
      resolve(8'h0C, 1'b1, 2'd3, pc);
      check("ghr_shift", {24'd0, ghr}, 32'h05);
      lookup({1'b1, 8'h05});

      for (int i = 0; i < 6; i++) tick();
      check("wr_queue_drained", exp_wr_q.size(), 32'd0);
      check("pred_queue_drained", exp_pred_q.size(), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
      $finish;
   end

endmodule
